regfile_banked_2r1w: RTL
========================

REGFILE_BANKED_2R1W -- requirements
Module: regfile_banked_2r1w

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, total entries; power of two.
REQ-003 SHALL have parameter BANKS, default 4, bank count; power of two, at most DEPTH.
REQ-004 SHALL derive AW = log2(DEPTH), BW = log2(BANKS), MW = WIDTH/8.
REQ-005 SHALL have one clock and a synchronous, active-low reset.
REQ-006 clock  input  1  rising-edge clock for all state.
REQ-007 reset_n  input  1  synchronous active-low reset.
REQ-008 w_en  input  1  write request.
REQ-009 w_addr  input  AW  write address.
REQ-010 w_data  input  WIDTH  write data.
REQ-011 w_mask  input  MW  byte enables; bit i covers w_data[8i+7:8i].
REQ-012 r0_valid  input  1  read port 0 request.
REQ-013 r0_ready  output  1  read port 0 accept.
REQ-014 r0_addr  input  AW  read port 0 address.
REQ-015 r0_rvalid  output  1  read port 0 response strobe.
REQ-016 r0_data  output  WIDTH  read port 0 data.
REQ-017 r1_valid, r1_ready, r1_addr, r1_rvalid, r1_data SHALL mirror the r0_* ports for read port 1.

Function
REQ-018 Bank select SHALL be addr[BW-1:0]; row within bank SHALL be addr[AW-1:BW].
REQ-019 Each bank SHALL have one read and one write access per cycle; writes never stall.
REQ-020 r0_ready SHALL be 1 whenever reset_n=1; port 0 has fixed priority.
REQ-021 r1_ready SHALL be 0 when r0_valid=1, r1_valid=1, banks equal and addresses differ (bank conflict); otherwise 1 whenever reset_n=1.
REQ-022 Identical r0_addr/r1_addr SHALL be a broadcast: both ports are accepted in the same cycle with equal data.
REQ-023 A read SHALL be accepted on a cycle with valid=1 and ready=1; rvalid SHALL pulse exactly one cycle later for exactly one cycle.
REQ-024 rX_data SHALL update only on the cycle rvalid pulses and SHALL hold its value until the next accepted read on that port.
REQ-025 The block SHALL keep a DEPTH-bit written bitmap; a write with w_en=1 and a nonzero w_mask SHALL set written[w_addr].
REQ-026 Stored value of an entry whose written bit is 0 SHALL be treated as all-zero for reads and for partial-mask merges; no X shall reach rX_data.
REQ-027 A write SHALL update only the bytes enabled by w_mask; w_mask=0 SHALL be a no-op, including no bitmap update.
REQ-028 Read-during-write to the same address in the same cycle SHALL be write-first: returned bytes = w_data where w_mask=1, old (or zero per REQ-026) elsewhere.
REQ-029 A stalled r1 request (ready=0) SHALL have no side effects; the requester holds valid/addr, and the request is accepted on the first non-conflicting cycle.
REQ-030 Latency from accept to data SHALL be 1 cycle for every case, including bypass and broadcast.

Reset
REQ-031 While reset_n=0 at a rising edge: bitmap cleared, r0_rvalid=r1_rvalid=0, r0_data=r1_data=0.
REQ-032 While reset_n=0, r0_ready and r1_ready SHALL be 0, and writes presented SHALL be ignored.
REQ-033 A read accepted the cycle before reset asserts SHALL NOT produce rvalid after the reset edge.
REQ-034 Array storage SHALL NOT require reset; the bitmap guarantees defined read data.

Verification
REQ-035 Reset, then r0 read addr 0x05 -> next cycle r0_rvalid=1, r0_data=0x00000000.
REQ-036 Write 0x05 = 0xAABBCCDD with mask 0xF, then write 0x05 = 0x11223344 with mask 0x5; read -> 0xAA22CC44.
REQ-037 Same cycle: write 0x09 = 0xDEADBEEF with mask 0x3 (entry unwritten) and r0 read 0x09 -> next cycle r0_data=0x0000BEEF.
REQ-038 r0 reads 0x04, r1 reads 0x08 (both bank 0, BANKS=4) -> r1_ready=0 in cycle 0; r0 data in cycle 1; r1 accepted in cycle 1 and data in cycle 2.
REQ-039 r0 and r1 both read 0x0C -> both ready=1, both rvalid in the next cycle with equal data.
REQ-040 Write 0x20 = 0x12345678 with mask 0xF, assert reset_n=0 for one cycle, then read 0x20 -> 0x00000000, and no rvalid is produced during reset.

Source files
------------

// File: rtl/regfile_banked_2r1w.sv
// Banked 2-read/1-write register file with byte-masked writes, a written-entry bitmap
// that makes unwritten entries read as zero, write-first bypass and bank-conflict stalling on read port 1.
module regfile_banked_2r1w #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned BANKS = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     w_en,
  input  logic [$clog2(DEPTH)-1:0] w_addr,
  input  logic [WIDTH-1:0]         w_data,
  input  logic [WIDTH/8-1:0]       w_mask,
  input  logic                     r0_valid,
  output logic                     r0_ready,
  input  logic [$clog2(DEPTH)-1:0] r0_addr,
  output logic                     r0_rvalid,
  output logic [WIDTH-1:0]         r0_data,
  input  logic                     r1_valid,
  output logic                     r1_ready,
  input  logic [$clog2(DEPTH)-1:0] r1_addr,
  output logic                     r1_rvalid,
  output logic [WIDTH-1:0]         r1_data
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned BW   = $clog2(BANKS);
  localparam int unsigned MW   = WIDTH / 8;
  localparam int unsigned ROWS = DEPTH / BANKS;
  localparam int unsigned BSW  = (BW > 0) ? BW : 1;
  localparam int unsigned RSW  = (AW > BW) ? (AW - BW) : 1;

  logic [WIDTH-1:0] mem [BANKS][ROWS];
  logic [DEPTH-1:0] written;

  logic [BSW-1:0] w_bank, r0_bank, r1_bank;
  logic [RSW-1:0] w_row, r0_row, r1_row;
  logic           w_active;
  logic           conflict_c;
  logic           r0_acc, r1_acc;

  logic [RSW-1:0]   bank_rrow  [BANKS];
  logic [WIDTH-1:0] bank_rdata [BANKS];

  logic [WIDTH-1:0] r0_old, r1_old;
  logic [MW-1:0]    r0_byp, r1_byp;
  logic [WIDTH-1:0] r0_next, r1_next;

  function automatic logic [BSW-1:0] bank_of(input logic [AW-1:0] a);
    bank_of = (BANKS == 1) ? '0 : BSW'(a);
  endfunction

  function automatic logic [RSW-1:0] row_of(input logic [AW-1:0] a);
    row_of = RSW'(a >> BW);
  endfunction

  function automatic logic [WIDTH-1:0] byte_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [MW-1:0]    sel);
    byte_merge = old_w;
    for (int i = 0; i < int'(MW); i++) begin
      if (sel[i]) byte_merge[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  assign w_bank  = bank_of(w_addr);
  assign r0_bank = bank_of(r0_addr);
  assign r1_bank = bank_of(r1_addr);
  assign w_row   = row_of(w_addr);
  assign r0_row  = row_of(r0_addr);
  assign r1_row  = row_of(r1_addr);

  assign w_active   = reset_n && w_en && (|w_mask);
  assign conflict_c = r0_valid && r1_valid && (r0_bank == r1_bank) && (r0_addr != r1_addr);
  assign r0_ready   = reset_n;
  assign r1_ready   = reset_n && !conflict_c;
  assign r0_acc     = r0_valid && r0_ready;
  assign r1_acc     = r1_valid && r1_ready;

  // Single read row per bank: port 0 owns its bank; a broadcast shares the same row.
  always_comb begin
    for (int b = 0; b < int'(BANKS); b++) begin
      bank_rrow[b] = r1_row;
      if (r0_valid && (r0_bank == BSW'(b))) bank_rrow[b] = r0_row;
      bank_rdata[b] = mem[b][bank_rrow[b]];
    end
  end

  always_comb begin
    r0_old  = written[r0_addr] ? bank_rdata[r0_bank] : '0;
    r1_old  = written[r1_addr] ? bank_rdata[r1_bank] : '0;
    r0_byp  = (w_active && (w_addr == r0_addr)) ? w_mask : '0;
    r1_byp  = (w_active && (w_addr == r1_addr)) ? w_mask : '0;
    r0_next = byte_merge(r0_old, w_data, r0_byp);
    r1_next = byte_merge(r1_old, w_data, r1_byp);
  end

  // First write to an entry zero-fills the unmasked bytes so stale contents never surface.
  always_ff @(posedge clock) begin
    if (w_active) begin
      for (int i = 0; i < int'(MW); i++) begin
        if (w_mask[i] || !written[w_addr])
          mem[w_bank][w_row][8*i +: 8] <= w_mask[i] ? w_data[8*i +: 8] : 8'h00;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      written   <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_data   <= '0;
      r1_data   <= '0;
    end else begin
      if (w_active) written[w_addr] <= 1'b1;
      r0_rvalid <= r0_acc;
      r1_rvalid <= r1_acc;
      if (r0_acc) r0_data <= r0_next;
      if (r1_acc) r1_data <= r1_next;
    end
  end

endmodule
